digit_data_path: RTL and testbench

//  Display data path downstream of the anode/segment-select scan FSM. Takes the
//  3-bit seg_sel digit index and a 32-bit address/data word (8 nibbles) and

---
 rtl/digit_data_path.sv | 123 ++++++++++++
 tb/tb_digit_data_path.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_data_path.sv
// digit_data_path: registered active-low 7-segment cathode drive with a
// double-buffered display word, leading-zero blanking and per-digit blink.
`timescale 1ns/1ps
module digit_data_path #(
   parameter int BLINK_FRAMES = 60,
   parameter int SYNC_STAGES  = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  seg_sel,
   input  logic [31:0] data_word,
   input  logic        load,
   input  logic        lz_en,
   input  logic [7:0]  blink_mask,
   input  logic [7:0]  dp_mask,
   output logic [6:0]  cath_n,
   output logic        dp_n,
   output logic        frame_tick,
   output logic        pend_valid
);

   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [SYNC_STAGES-1:0][2:0] sync_q;
   logic [2:0]    sel_s;
   logic [2:0]    sel_d;
   logic [31:0]   pend;
   logic [31:0]   shown;
   logic [BW-1:0] blink_cnt;
   logic          blink_ph;
   logic [3:0]    nib;
   logic          lz_blank;
   logic          blank;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      unique case (n)
         4'h0: s = 7'b0000001;
         4'h1: s = 7'b1001111;
         4'h2: s = 7'b0010010;
         4'h3: s = 7'b0000110;
         4'h4: s = 7'b1001100;
         4'h5: s = 7'b0100100;
         4'h6: s = 7'b0100000;
         4'h7: s = 7'b0001111;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0000100;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b1100000;
         4'hC: s = 7'b0110001;
         4'hD: s = 7'b1000010;
         4'hE: s = 7'b0110000;
         4'hF: s = 7'b0111000;
      endcase
      return s;
   endfunction

   assign sel_s = sync_q[SYNC_STAGES-1];

   // seg_sel comes from the divided-clock scan FSM
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= '0;
         sel_d      <= '0;
         frame_tick <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SYNC_STAGES-2:0], seg_sel};
         sel_d      <= sel_s;
         frame_tick <= (sel_d == 3'd7) && (sel_s == 3'd0);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend       <= '0;
         pend_valid <= 1'b0;
         shown      <= '0;
      end else begin
         if (frame_tick && pend_valid)
            shown <= pend;
         if (load) begin
            pend       <= data_word;
            pend_valid <= 1'b1;
         end else if (frame_tick) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         blink_cnt <= '0;
         blink_ph  <= 1'b0;
      end else if (frame_tick) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
         end else begin
            blink_cnt <= blink_cnt + 1'b1;
         end
      end
   end

   // a digit is a leading zero when it and every higher nibble are zero
   always_comb begin
      nib      = shown[{sel_s, 2'b00} +: 4];
      lz_blank = lz_en && (sel_s != 3'd0)
                 && ((shown >> {sel_s, 2'b00}) == 32'd0);
      blank    = (blink_ph && blink_mask[sel_s]) || lz_blank;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cath_n <= 7'h7F;
         dp_n   <= 1'b1;
      end else begin
         cath_n <= blank ? 7'h7F : hex7(nib);
         dp_n   <= ~(dp_mask[sel_s] && !blank);
      end
   end

endmodule

// File: tb/tb_digit_data_path.sv
// tb_digit_data_path: random scan/load stimulus checked every cycle against
// a behavioural display model, plus directed literal display checks.
`timescale 1ns/1ps
module tb_digit_data_path;

   localparam int BF = 2;
   localparam int SS = 2;
   localparam logic [6:0] OFF = 7'h7F;
   localparam logic [6:0] HEX [16] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
      7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
      7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
      7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [2:0]  seg_sel = '0;
   logic [31:0] data_word = '0;
   logic        load = 1'b0;
   logic        lz_en = 1'b0;
   logic [7:0]  blink_mask = '0;
   logic [7:0]  dp_mask = '0;
   logic [6:0]  cath_n;
   logic        dp_n;
   logic        frame_tick;
   logic        pend_valid;

   int n_vec = 0;
   int n_err = 0;

   digit_data_path #(.BLINK_FRAMES(BF), .SYNC_STAGES(SS)) dut (
      .clk(clk), .reset_n(reset_n), .seg_sel(seg_sel),
      .data_word(data_word), .load(load), .lz_en(lz_en),
      .blink_mask(blink_mask), .dp_mask(dp_mask), .cath_n(cath_n),
      .dp_n(dp_n), .frame_tick(frame_tick), .pend_valid(pend_valid));

   always #5 clk = ~clk;

   // model state: pin history, word buffers, blink frame count
   logic [2:0]  m_pin [SS+1];
   logic [31:0] m_shown, m_pend;
   logic        m_pv, m_ft, m_ph;
   int          m_cnt;
   logic [6:0]  e_cath;
   logic        e_dp;

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic m_blank(int d);
      logic lead;
      lead = lz_en && (d != 0);
      for (int j = d; j < 8; j++)
         if (m_shown[4*j +: 4] != 4'h0) lead = 1'b0;
      return (m_ph && blink_mask[d]) || lead;
   endfunction

   task automatic model_reset();
      for (int k = 0; k <= SS; k++) m_pin[k] = '0;
      m_shown = '0; m_pend = '0; m_pv = 0; m_ft = 0;
      m_ph = 0; m_cnt = 0; e_cath = OFF; e_dp = 1'b1;
   endtask

   task automatic model_step();
      int   s;
      logic b;
      s = int'(m_pin[SS-1]);
      b = m_blank(s);
      e_cath = b ? OFF : HEX[m_shown[4*s +: 4]];
      e_dp = !(dp_mask[s] && !b);
      if (m_ft) begin
         if (m_pv) m_shown = m_pend;
         m_cnt++;
         if (m_cnt == BF) begin
            m_cnt = 0;
            m_ph = !m_ph;
         end
      end
      if (load) begin
         m_pend = data_word;
         m_pv = 1'b1;
      end else if (m_ft) begin
         m_pv = 1'b0;
      end
      m_ft = (m_pin[SS] == 3'd7) && (m_pin[SS-1] == 3'd0);
      for (int k = SS; k > 0; k--) m_pin[k] = m_pin[k-1];
      m_pin[0] = seg_sel;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge reset_n);
         if (!reset_n) model_reset();
         else model_step();
      end
   end

   initial forever begin
      @(negedge clk);
      if (reset_n) begin
         check("cath_n", 32'(cath_n), 32'(e_cath));
         check("dp_n", 32'(dp_n), 32'(e_dp));
         check("frame_tick", 32'(frame_tick), 32'(m_ft));
         check("pend_valid", 32'(pend_valid), 32'(m_pv));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic show(int d, int hold);
      seg_sel = 3'(d);
      step(hold);
   endtask

   task automatic frame();
      for (int d = 0; d < 8; d++) show(d, 8);
   endtask

   task automatic frame_chk(string nm, logic [7:0][6:0] exp);
      for (int d = 0; d < 8; d++) begin
         show(d, 8);
         check($sformatf("%s.d%0d", nm, d), 32'(cath_n), 32'(exp[d]));
      end
   endtask

   task automatic pulse_load(logic [31:0] w);
      data_word = w;
      load = 1'b1;
      step(1);
      load = 1'b0;
      data_word = $urandom;
   endtask

   task automatic rand_run(int cycles);
      int d;
      int h;
      d = 0;
      for (int c = 0; c < cycles; c += h) begin
         h = $urandom_range(1, 6);
         if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 7);
         else d = (d + 1) % 8;
         seg_sel = 3'(d);
         if ($urandom_range(0, 15) == 0) lz_en = 1'($urandom);
         if ($urandom_range(0, 15) == 0) blink_mask = 8'($urandom);
         if ($urandom_range(0, 15) == 0) dp_mask = 8'($urandom);
         for (int k = 0; k < h; k++) begin
            load = ($urandom_range(0, 19) == 0);
            data_word = $urandom >> (4 * $urandom_range(0, 8));
            step(1);
         end
      end
      load = 1'b0;
   endtask

   logic blk [8];
   int   t;

   initial begin
      @(negedge clk);
      step(3);
      reset_n = 1'b1;
      rand_run(3000);

      // mid-scan reset
      lz_en = 0; blink_mask = 0; dp_mask = 8'hFF;
      seg_sel = 3'd3;
      step(4);
      pulse_load(32'h0000_0009);
      step(3);
      check("t1_pre_pv", 32'(pend_valid), 32'd1);
      #2 reset_n = 1'b0;
      #1;
      check("t1_rst_cath", 32'(cath_n), 32'h7F);
      check("t1_rst_dp", 32'(dp_n), 32'd1);
      check("t1_rst_pv", 32'(pend_valid), 32'd0);
      check("t1_rst_ft", 32'(frame_tick), 32'd0);
      step(3);
      reset_n = 1'b1;
      lz_en = 1; dp_mask = 0;
      frame();
      frame_chk("t1", {OFF, OFF, OFF, OFF, OFF, OFF, OFF, 7'b0000001});

      // load mid-frame
      show(0, 8); show(1, 8); show(2, 8); show(3, 4);
      pulse_load(32'h1234_ABCD);
      check("t2_pv", 32'(pend_valid), 32'd1);
      show(3, 3);
      for (int d = 4; d < 8; d++) begin
         show(d, 8);
         check($sformatf("t2_old.d%0d", d), 32'(cath_n), 32'(OFF));
      end
      frame_chk("t2", {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                       7'b0001000, 7'b1100000, 7'b0110001, 7'b1000010});
      check("t2_pv_clr", 32'(pend_valid), 32'd0);

      // leading-zero blanking on and off
      pulse_load(32'h0000_00F0);
      frame_chk("t3lz", {OFF, OFF, OFF, OFF, OFF, OFF,
                         7'b0111000, 7'b0000001});
      lz_en = 0;
      frame_chk("t3nolz", {7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001,
                           7'b0000001, 7'b0000001, 7'b0111000, 7'b0000001});

      // load coincident with frame_tick
      lz_en = 1;
      pulse_load(32'h8765_4321);
      seg_sel = 3'd0;
      t = 0;
      while (frame_tick !== 1'b1 && t < 10) begin
         step(1);
         t++;
      end
      check("t4_ft_seen", 32'(frame_tick), 32'd1);
      data_word = 32'h0000_0E00;
      load = 1'b1;
      step(1);
      load = 1'b0;
      check("t4_pv", 32'(pend_valid), 32'd1);
      step(6);
      check("t4_w1.d0", 32'(cath_n), 32'(7'b1001111));
      begin
         logic [7:0][6:0] w1;
         w1 = {7'b0000000, 7'b0001111, 7'b0100000, 7'b0100100,
               7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111};
         for (int d = 1; d < 8; d++) begin
            show(d, 8);
            check($sformatf("t4_w1.d%0d", d), 32'(cath_n), 32'(w1[d]));
         end
      end
      check("t4_pv_hold", 32'(pend_valid), 32'd1);
      frame_chk("t4_w2", {OFF, OFF, OFF, OFF, OFF,
                          7'b0110000, 7'b0000001, 7'b0000001});
      check("t4_pv_clr", 32'(pend_valid), 32'd0);

      // blink on digit 0 only, two frames per half-period
      lz_en = 0;
      blink_mask = 8'h01;
      for (int f = 0; f < 8; f++) begin
         show(0, 8);
         blk[f] = (cath_n == OFF);
         check($sformatf("t5_d0_f%0d", f),
               32'(blk[f] ? cath_n : 7'b0000001), 32'(cath_n));
         show(1, 8);
         check($sformatf("t5_d1_f%0d", f), 32'(cath_n), 32'(7'b0000001));
         for (int d = 2; d < 8; d++) show(d, 4);
      end
      for (int f = 0; f < 6; f++)
         check($sformatf("t5_alt_f%0d", f), 32'(blk[f+2]), 32'(!blk[f]));

      // decimal point latency
      blink_mask = 0;
      dp_mask = 8'h10;
      show(3, 8);
      check("t6_dp3", 32'(dp_n), 32'd1);
      seg_sel = 3'd4;
      step(1);
      check("t6_dp_c1", 32'(dp_n), 32'd1);
      step(1);
      check("t6_dp_c2", 32'(dp_n), 32'd1);
      step(1);
      check("t6_dp_c3", 32'(dp_n), 32'd0);
      step(5);
      for (int d = 5; d < 11; d++) begin
         show(d % 8, 8);
         check($sformatf("t6_dp_d%0d", d % 8), 32'(dp_n), 32'd1);
      end

      rand_run(2000);
      step(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
